// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared state and grant encodings for the packet arbiter
package axis_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_P0   = 2'b01;
    localparam logic [1:0] GRANT_P1   = 2'b10;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            GNT0:    grant_of = GRANT_P0;
            GNT1:    grant_of = GRANT_P1;
            default: grant_of = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; last is the index granted most recently
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// rtl/axis_pkt_arbiter.sv - packet-granular two-port AXIS arbiter, combinational datapath
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,

    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic [KEEP_W-1:0] s0_axis_tkeep,
    input  logic              s0_axis_tlast,
    input  logic              s0_axis_tuser,

    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic [KEEP_W-1:0] s1_axis_tkeep,
    input  logic              s1_axis_tlast,
    input  logic              s1_axis_tuser,

    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,

    output logic [1:0]        grant,
    output logic [31:0]       pkt_cnt0,
    output logic [31:0]       pkt_cnt1
);

    arb_state_t state;
    logic       last_grant;
    logic [1:0] pick;
    logic       pkt_end;

    rr_pick2 u_pick (
        .req  ({s1_axis_tvalid, s0_axis_tvalid}),
        .last (last_grant),
        .pick (pick)
    );

    assign pkt_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign grant   = grant_of(state);

    // Grant is only re-evaluated in IDLE, so a packet is never split between owners.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick[0]) begin
                        state <= GNT0;
                    end else if (pick[1]) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (pkt_end) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                        pkt_cnt0   <= pkt_cnt0 + 32'd1;
                    end
                end
                GNT1: begin
                    if (pkt_end) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                        pkt_cnt1   <= pkt_cnt1 + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            GNT0: begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tlast   = s0_axis_tlast;
                m_axis_tuser   = s0_axis_tuser;
                s0_axis_tready = m_axis_tready;
            end
            GNT1: begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tlast   = s1_axis_tlast;
                m_axis_tuser   = s1_axis_tuser;
                s1_axis_tready = m_axis_tready;
            end
            default: ;
        endcase
    end

endmodule
